// File: rtl/cellular_ram_responder.sv
// Cycle-accurate stand-in for a Micron CellularRAM in synchronous burst mode.
// Answers BCR configuration writes and variable-latency read/write bursts from
// a small on-chip backing store, driving WAIT with the configured polarity.
module cellular_ram_responder #(
   parameter int ADDR_WIDTH = 20,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  CLK,
   input  logic                  ResetN,
   input  logic [ADDR_WIDTH-1:0] ConAddr,
   input  logic [15:0]           DqIn,
   output logic [15:0]           DqOut,
   output logic                  DqOE,
   input  logic                  ConCE,
   input  logic                  ConWE,
   input  logic                  ConOE,
   input  logic                  ConADV,
   input  logic                  ConLB,
   input  logic                  ConUB,
   input  logic                  ConCRE,
   output logic                  Wait
);

   localparam int          DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [15:0] BCR_RESET = 16'h9D1F;  // latency 3, WAIT active high, continuous

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LATENCY,
      ST_DATA,
      ST_HOLD
   } state_e;

   state_e                state_q, state_d;
   logic [15:0]           bcr_q, bcr_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [2:0]            lat_cnt_q, lat_cnt_d;
   logic [4:0]            beat_cnt_q, beat_cnt_d;
   logic [15:0]           dq_out_q, dq_out_d;
   logic [15:0]           mem_q [DEPTH];

   logic [2:0]            eff_latency;
   logic                  fixed_burst;
   logic [4:0]            burst_len;
   logic [DEPTH_LOG2-1:0] wrap_mask;
   logic [DEPTH_LOG2-1:0] addr_inc;
   logic [DEPTH_LOG2-1:0] addr_next;
   logic                  mem_we;

   // BCR bits and upper bus address bits with no meaning for this responder.
   logic unused_bits;
   assign unused_bits = ^{ConAddr[ADDR_WIDTH-1:16], bcr_q[15:14], bcr_q[9:3]};

   // Decode the BCR latency code; reserved codes fall back to latency 3.
   always_comb begin
      case (bcr_q[13:11])
         3'd2, 3'd3, 3'd4, 3'd5, 3'd6: eff_latency = bcr_q[13:11];
         default:                      eff_latency = 3'd3;
      endcase
   end

   // Decode the BCR burst length; reserved codes behave as continuous.
   always_comb begin
      // NOTE: every signal gets a value before the case so no path leaves it unassigned (no latch).
      fixed_burst = 1'b1;
      burst_len   = 5'd0;
      wrap_mask   = '0;
      case (bcr_q[2:0])
         3'b001: begin burst_len = 5'd4;  wrap_mask = DEPTH_LOG2'(3);  end
         3'b010: begin burst_len = 5'd8;  wrap_mask = DEPTH_LOG2'(7);  end
         3'b011: begin burst_len = 5'd16; wrap_mask = DEPTH_LOG2'(15); end
         default: fixed_burst = 1'b0;
      endcase
   end

   // Next beat address: wrap inside the aligned block for fixed bursts, linear otherwise.
   always_comb begin
      addr_inc = addr_q + DEPTH_LOG2'(1);
      if (fixed_burst) begin
         addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      end else begin
         addr_next = addr_inc;
      end
   end

   // State register and burst datapath registers.
   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         state_q    <= ST_IDLE;
         bcr_q      <= BCR_RESET;
         addr_q     <= '0;
         write_q    <= 1'b0;
         lat_cnt_q  <= '0;
         beat_cnt_q <= '0;
         dq_out_q   <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state_q    <= state_d;
         bcr_q      <= bcr_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         lat_cnt_q  <= lat_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         dq_out_q   <= dq_out_d;
      end
   end

   // Next-state and datapath update; deselecting the chip abandons any burst.
   always_comb begin
      state_d    = state_q;
      bcr_d      = bcr_q;
      addr_d     = addr_q;
      write_d    = write_q;
      lat_cnt_d  = lat_cnt_q;
      beat_cnt_d = beat_cnt_q;
      dq_out_d   = dq_out_q;
      if (ConCE) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!ConADV) begin
                  if (ConCRE) begin
                     if (!ConWE) bcr_d = ConAddr[15:0];
                  end else begin
                     addr_d    = ConAddr[DEPTH_LOG2-1:0];
                     write_d   = ~ConWE;
                     lat_cnt_d = eff_latency - 3'd1;
                     state_d   = ST_LATENCY;
                  end
               end
            end
            ST_LATENCY: begin
               lat_cnt_d = lat_cnt_q - 3'd1;
               if (lat_cnt_q == 3'd1) begin
                  state_d    = ST_DATA;
                  beat_cnt_d = burst_len;
                  if (!write_q) dq_out_d = mem_q[addr_q];
               end
            end
            ST_DATA: begin
               addr_d = addr_next;
               if (!write_q) dq_out_d = mem_q[addr_next];
               if (fixed_burst) begin
                  beat_cnt_d = beat_cnt_q - 5'd1;
                  if (beat_cnt_q == 5'd1) state_d = ST_HOLD;
               end
            end
            ST_HOLD: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Pin outputs: DQ enable and WAIT follow the chip-select and output-enable pins immediately.
   always_comb begin
      DqOE = (state_q == ST_DATA) && !write_q && !ConOE && !ConCE;
      Wait = ~bcr_q[10];
      if ((state_q == ST_LATENCY) && !ConCE) Wait = bcr_q[10];
   end

   assign DqOut  = dq_out_q;
   assign mem_we = (state_q == ST_DATA) && write_q && !ConCE;

   // Backing store write port with per-byte enables.
   always_ff @(posedge CLK) begin
      // NOTE: the memory array has no reset; its contents are undefined until written.
      if (mem_we) begin
         if (!ConLB) mem_q[addr_q][7:0]  <= DqIn[7:0];
         if (!ConUB) mem_q[addr_q][15:8] <= DqIn[15:8];
      end
   end

endmodule
